regwrite_trace_fifo: RTL and testbench

//   Debug trace buffer that sits directly downstream of the MIPS register-file write port.

---
 rtl/regwrite_trace_fifo.sv | 105 ++++++++++
 tb/tb_regwrite_trace_fifo.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/regwrite_trace_fifo.sv
// Trace FIFO for register-file writes: records (register, value, cycle stamp) for masked
// registers and drains them over a show-ahead valid/ready stream.
module regwrite_trace_fifo #(
    parameter int DEPTH   = 8,
    parameter int ADDR_W  = 5,
    parameter int DATA_W  = 32,
    parameter int STAMP_W = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic [31:0]                trace_mask,
    input  logic                       clear,
    output logic                       trace_valid,
    input  logic                       trace_ready,
    output logic [ADDR_W-1:0]          trace_addr,
    output logic [DATA_W-1:0]          trace_data,
    output logic [STAMP_W-1:0]         trace_stamp,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [7:0]                 drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ADDR_W-1:0]  mem_addr  [DEPTH];
    logic [DATA_W-1:0]  mem_data  [DEPTH];
    logic [STAMP_W-1:0] mem_stamp [DEPTH];

    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [STAMP_W-1:0] stamp;
    logic               push_req;
    logic               pop;
    logic               full;
    logic               push;
    logic               drop;

    assign push_req    = wr_en & trace_mask[wr_addr] & (wr_addr != '0);
    assign trace_valid = (count != '0);
    assign pop         = trace_valid & trace_ready;
    assign full        = (count == CNT_W'(DEPTH));
    // A pop frees the head slot on the same edge, so a full FIFO can still accept.
    assign push        = push_req & (~full | pop);
    assign drop        = push_req & full & ~pop;

    // Head record is masked while empty so stale entries never leak onto the stream.
    assign trace_addr  = trace_valid ? mem_addr[rd_ptr]  : '0;
    assign trace_data  = trace_valid ? mem_data[rd_ptr]  : '0;
    assign trace_stamp = trace_valid ? mem_stamp[rd_ptr] : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stamp <= '0;
        end else begin
            stamp <= stamp + STAMP_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) begin
            mem_addr[wr_ptr]  <= wr_addr;
            mem_data[wr_ptr]  <= wr_data;
            mem_stamp[wr_ptr] <= stamp;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (clear) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 8'hFF) begin
                    drop_count <= drop_count + 8'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_regwrite_trace_fifo.sv
// Directed bench for regwrite_trace_fifo: reset, masking, $zero, overflow, full+pop,
// clear and asynchronous reset mid-stream.
module tb_regwrite_trace_fifo;

    logic        clk = 1'b0;
    logic        reset;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] trace_mask;
    logic        clear;
    logic        trace_valid;
    logic        trace_ready;
    logic [4:0]  trace_addr;
    logic [31:0] trace_data;
    logic [15:0] trace_stamp;
    logic [3:0]  count;
    logic        overflow;
    logic [7:0]  drop_count;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int exp_stamp [10];
    int s0;

    regwrite_trace_fifo #(.DEPTH(8), .ADDR_W(5), .DATA_W(32), .STAMP_W(16)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .trace_mask(trace_mask), .clear(clear), .trace_valid(trace_valid),
        .trace_ready(trace_ready), .trace_addr(trace_addr), .trace_data(trace_data),
        .trace_stamp(trace_stamp), .count(count), .overflow(overflow), .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        cyc = cyc + 1;
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, ".valid"}, 64'(trace_valid), 64'd0);
        chk({tag, ".count"}, 64'(count), 64'd0);
        chk({tag, ".ovf"},   64'(overflow), 64'd0);
        chk({tag, ".drops"}, 64'(drop_count), 64'd0);
        chk({tag, ".addr"},  64'(trace_addr), 64'd0);
        chk({tag, ".data"},  64'(trace_data), 64'd0);
        chk({tag, ".stamp"}, 64'(trace_stamp), 64'd0);
    endtask

    task automatic chk_head(input string tag, input int a, input int d, input int s);
        chk({tag, ".valid"}, 64'(trace_valid), 64'd1);
        chk({tag, ".addr"},  64'(trace_addr), 64'(a));
        chk({tag, ".data"},  64'(trace_data), 64'(d));
        chk({tag, ".stamp"}, 64'(trace_stamp), 64'(s & 16'hFFFF));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        trace_mask = '0; clear = 1'b0; trace_ready = 1'b0;

        // 1. reset: outputs zero during and after reset, stamp counts from release
        #1;
        chk_idle("rst_active");
        #9;
        reset = 1'b0;
        cyc = 0;
        repeat (3) tick();
        chk_idle("rst_idle");

        // 2. masking and ordering; count==1 push+pop keeps valid
        trace_mask = 32'h0000_0F00;
        trace_ready = 1'b1;
        wr_en = 1'b1; wr_addr = 5'd8; wr_data = 32'd5; s0 = cyc;
        chk("stamp_after_reset", 64'(s0), 64'd3);
        tick();
        chk_head("cap8", 8, 5, s0);
        chk("cap8.count", 64'(count), 64'd1);
        wr_addr = 5'd9; wr_data = 32'd7;
        tick();
        chk_head("cap9", 9, 7, s0 + 1);
        chk("cap9.count", 64'(count), 64'd1);
        wr_addr = 5'd12; wr_data = 32'd99;
        tick();
        chk("mask12.count", 64'(count), 64'd0);
        chk("mask12.valid", 64'(trace_valid), 64'd0);

        // 3. $zero never recorded
        trace_mask = 32'hFFFF_FFFF;
        trace_ready = 1'b0;
        wr_addr = 5'd0; wr_data = 32'hDEAD;
        tick();
        wr_en = 1'b0;
        tick();
        chk("zero.count", 64'(count), 64'd0);
        chk("zero.valid", 64'(trace_valid), 64'd0);

        // 4. overflow: 10 writes into 8 slots
        wr_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            wr_addr = 5'(i + 1); wr_data = 32'(100 + i); exp_stamp[i] = cyc;
            tick();
        end
        wr_en = 1'b0;
        chk("ovf.count", 64'(count), 64'd8);
        chk("ovf.flag",  64'(overflow), 64'd1);
        chk("ovf.drops", 64'(drop_count), 64'd2);
        trace_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            chk_head($sformatf("ovf_drain%0d", i), i + 1, 100 + i, exp_stamp[i]);
            tick();
        end
        chk("ovf_drained.count", 64'(count), 64'd0);
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // 5. full with simultaneous pop: push accepted, no overflow
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("clr1.ovf",   64'(overflow), 64'd0);
        chk("clr1.drops", 64'(drop_count), 64'd0);
        trace_ready = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wr_addr = 5'(16 + i); wr_data = 32'(200 + i); exp_stamp[i] = cyc;
            tick();
        end
        chk("full.count", 64'(count), 64'd8);
        wr_addr = 5'd30; wr_data = 32'd999; exp_stamp[8] = cyc;
        trace_ready = 1'b1;
        tick();
        wr_en = 1'b0;
        chk("fullpop.count", 64'(count), 64'd8);
        chk("fullpop.ovf",   64'(overflow), 64'd0);
        chk("fullpop.drops", 64'(drop_count), 64'd0);
        for (int i = 1; i < 8; i++) begin
            chk_head($sformatf("fp_drain%0d", i), 16 + i, 200 + i, exp_stamp[i]);
            tick();
        end
        chk_head("fp_last", 30, 999, exp_stamp[8]);
        tick();
        chk("fp_empty.count", 64'(count), 64'd0);

        // 6a. clear with a simultaneous push: everything flushed, push lost
        trace_ready = 1'b0;
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_addr = 5'(3 + i); wr_data = 32'(300 + i);
            tick();
        end
        chk("pre_clear.count", 64'(count), 64'd4);
        wr_addr = 5'd5; wr_data = 32'd55; clear = 1'b1;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        chk("clr2.count", 64'(count), 64'd0);
        chk("clr2.valid", 64'(trace_valid), 64'd0);
        chk("clr2.ovf",   64'(overflow), 64'd0);
        chk("clr2.drops", 64'(drop_count), 64'd0);
        tick();
        chk("clr2_late.count", 64'(count), 64'd0);

        // 6b. asynchronous reset mid-stream, then stamp restarts from zero
        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd70;
        tick();
        wr_addr = 5'd8; wr_data = 32'd80;
        tick();
        wr_en = 1'b0;
        chk("pre_rst.count", 64'(count), 64'd2);
        chk("pre_rst.valid", 64'(trace_valid), 64'd1);
        #1;
        reset = 1'b1;
        #1;
        chk_idle("async_rst");
        #1;
        reset = 1'b0;
        cyc = 0;
        repeat (2) tick();
        wr_en = 1'b1; wr_addr = 5'd11; wr_data = 32'd1111; s0 = cyc;
        tick();
        wr_en = 1'b0;
        chk_head("post_rst", 11, 1111, 2);
        chk("post_rst.count", 64'(count), 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
